// File: rtl/vx_alu_sched_pkg.sv
// Shared types and constants for the ALU issue scheduler: output-buffer state
// encoding, credit counter width and an index-width helper.
package vx_alu_sched_pkg;

   localparam int CREDIT_W = 4;

   typedef enum logic {
      ALU_SCHED_EMPTY = 1'b0,
      ALU_SCHED_FULL  = 1'b1
   } buf_state_e;

   // A single-slot configuration still needs a 1-bit select/pointer.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_alu_sched_rr.sv
// Round-robin selector: picks the first eligible slot strictly after ptr,
// wrapping around, and returns it both one-hot and as an index.
module vx_alu_sched_rr #(
   parameter int NUM_REQS = 4,
   parameter int IDX_W    = 2
) (
   input  logic [NUM_REQS-1:0] eligible,
   input  logic [IDX_W-1:0]    ptr,
   output logic [NUM_REQS-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                grant_valid
);

   logic [IDX_W-1:0] slot;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      slot        = '0;
      // Offset k=NUM_REQS revisits ptr itself last, so it can win when alone.
      for (int k = 1; k <= NUM_REQS; k++) begin
         slot = IDX_W'((int'(ptr) + k) % NUM_REQS);
         if (!grant_valid && eligible[slot]) begin
            grant[slot] = 1'b1;
            grant_idx   = slot;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vx_alu_sched.sv
// Shared-ALU issue scheduler: round-robin over issue slots into a one-entry
// output buffer, with muldiv credit tracking. Define VX_ALU_SCHED_PERF_EN to
// add the perf_stalls counter output.
module vx_alu_sched
   import vx_alu_sched_pkg::*;
#(
   parameter int NUM_REQS    = 4,
   parameter int DATAW       = 64,
   parameter int MDV_CREDITS = 4,
   localparam int SEL_W      = idx_width(NUM_REQS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   input  logic [NUM_REQS-1:0]       req_is_mdv,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic                      out_valid,
   output logic [DATAW-1:0]          out_data,
   output logic                      out_is_mdv,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready,
   input  logic                      mdv_done,
   output logic [CREDIT_W-1:0]       mdv_credits
`ifdef VX_ALU_SCHED_PERF_EN
   ,
   output logic [31:0]               perf_stalls
`endif
);

   localparam logic [CREDIT_W-1:0] MAX_CREDITS = CREDIT_W'(MDV_CREDITS);

   buf_state_e          state_q, state_d;
   logic [DATAW-1:0]    out_data_q, out_data_d;
   logic                out_is_mdv_q, out_is_mdv_d;
   logic [SEL_W-1:0]    out_sel_q, out_sel_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;

   logic                can_grant;
   logic [NUM_REQS-1:0] eligible;
   logic [NUM_REQS-1:0] rr_grant;
   logic [SEL_W-1:0]    rr_idx;
   logic                rr_valid;
   logic                grant_fire;
   logic                take_credit;
   logic                give_credit;

   // A slot may only win when the buffer frees up this cycle.
   assign can_grant = (state_q == ALU_SCHED_EMPTY) || out_ready;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         eligible[i] = can_grant && req_valid[i] && (!req_is_mdv[i] || (credits_q != '0));
      end
   end

   vx_alu_sched_rr #(
      .NUM_REQS (NUM_REQS),
      .IDX_W    (SEL_W)
   ) u_rr (
      .eligible    (eligible),
      .ptr         (rr_ptr_q),
      .grant       (rr_grant),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   assign grant_fire  = rr_valid && !reset;
   assign req_ready   = reset ? '0 : rr_grant;
   assign take_credit = grant_fire && req_is_mdv[rr_idx];
   // A return at full credits is an upstream bug; drop it rather than overflow.
   assign give_credit = mdv_done && (credits_q != MAX_CREDITS);

   always_comb begin
      state_d      = state_q;
      out_data_d   = out_data_q;
      out_is_mdv_d = out_is_mdv_q;
      out_sel_d    = out_sel_q;
      rr_ptr_d     = rr_ptr_q;
      credits_d    = credits_q;

      if (grant_fire) begin
         state_d      = ALU_SCHED_FULL;
         out_data_d   = req_data[int'(rr_idx)*DATAW +: DATAW];
         out_is_mdv_d = req_is_mdv[rr_idx];
         out_sel_d    = rr_idx;
         rr_ptr_d     = rr_idx;
      end else if (out_ready) begin
         state_d = ALU_SCHED_EMPTY;
      end

      if (take_credit && !give_credit) begin
         credits_d = credits_q - 1'b1;
      end else if (give_credit && !take_credit) begin
         credits_d = credits_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ALU_SCHED_EMPTY;
         out_data_q   <= '0;
         out_is_mdv_q <= 1'b0;
         out_sel_q    <= '0;
         rr_ptr_q     <= SEL_W'(NUM_REQS - 1);
         credits_q    <= MAX_CREDITS;
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_is_mdv_q <= out_is_mdv_d;
         out_sel_q    <= out_sel_d;
         rr_ptr_q     <= rr_ptr_d;
         credits_q    <= credits_d;
      end
   end

   assign out_valid   = (state_q == ALU_SCHED_FULL);
   assign out_data    = out_data_q;
   assign out_is_mdv  = out_is_mdv_q;
   assign out_sel     = out_sel_q;
   assign mdv_credits = credits_q;

   mdv_overflow_a: assert property (@(posedge clk) disable iff (reset)
      !(mdv_done && (credits_q == MAX_CREDITS)));

`ifdef VX_ALU_SCHED_PERF_EN
   logic [31:0] perf_stalls_q, perf_stalls_d;

   always_comb begin
      perf_stalls_d = perf_stalls_q;
      if ((|req_valid) && !grant_fire) begin
         perf_stalls_d = perf_stalls_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stalls_q <= '0;
      end else begin
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_alu_sched.sv
// Directed self-checking bench for vx_alu_sched (4 slots, 2 muldiv credits).
// Also covers perf_stalls when built with VX_ALU_SCHED_PERF_EN.
module tb_vx_alu_sched;

   localparam int NUM_REQS    = 4;
   localparam int DATAW       = 64;
   localparam int MDV_CREDITS = 2;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQS-1:0]       req_valid;
   logic [NUM_REQS*DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]       req_is_mdv;
   logic [NUM_REQS-1:0]       req_ready;
   logic                      out_valid;
   logic [DATAW-1:0]          out_data;
   logic                      out_is_mdv;
   logic [1:0]                out_sel;
   logic                      out_ready;
   logic                      mdv_done;
   logic [3:0]                mdv_credits;
`ifdef VX_ALU_SCHED_PERF_EN
   logic [31:0]               perf_stalls;
`endif

   int checks = 0;
   int errors = 0;

   vx_alu_sched #(
      .NUM_REQS    (NUM_REQS),
      .DATAW       (DATAW),
      .MDV_CREDITS (MDV_CREDITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_is_mdv  (req_is_mdv),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_is_mdv  (out_is_mdv),
      .out_sel     (out_sel),
      .out_ready   (out_ready),
      .mdv_done    (mdv_done),
      .mdv_credits (mdv_credits)
`ifdef VX_ALU_SCHED_PERF_EN
      ,
      .perf_stalls (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and land 1ns after the edge, away from it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]          exp_sel [4];
      logic                exp_mdv [4];
      logic [3:0]          exp_cred[4];
      logic [NUM_REQS-1:0] exp_rdy [4];

      reset      = 1'b1;
      req_valid  = 4'hF;
      req_is_mdv = 4'h0;
      out_ready  = 1'b1;
      mdv_done   = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) req_data[i*DATAW +: DATAW] = 64'hA0 + 64'(i);

      // Reset state, with all slots requesting
      applyStimulus();
      applyStimulus();
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data", out_data, 64'd0);
      checkOutput("rst_out_sel", 64'(out_sel), 64'd0);
      checkOutput("rst_out_is_mdv", 64'(out_is_mdv), 64'd0);
      checkOutput("rst_credits", 64'(mdv_credits), 64'd2);
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);

      // Round-robin 0,1,2,3,0 at full throughput
      reset = 1'b0;
      #1;
      checkOutput("rr_first_ready", 64'(req_ready), 64'b0001);
      for (int c = 0; c < 5; c++) begin
         applyStimulus();
         checkOutput("rr_out_valid", 64'(out_valid), 64'd1);
         checkOutput("rr_out_sel", 64'(out_sel), 64'(c % 4));
         checkOutput("rr_out_data", out_data, 64'hA0 + 64'(c % 4));
         checkOutput("rr_req_ready", 64'(req_ready), 64'(1 << ((c + 1) % 4)));
      end

      // Drop requests: buffer drains and nothing new is taken
      req_valid = 4'h0;
      applyStimulus();
      checkOutput("drain_out_valid", 64'(out_valid), 64'd0);

      // Backpressure with slot 2 requesting
      req_valid = 4'b0100;
      out_ready = 1'b0;
      #1;
      checkOutput("bp_ready_empty", 64'(req_ready), 64'b0100);
      applyStimulus();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
         checkOutput("bp_out_sel", 64'(out_sel), 64'd2);
         checkOutput("bp_out_data", out_data, 64'hA2);
         checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
         applyStimulus();
      end
      out_ready = 1'b1;
      req_valid = 4'h0;
      applyStimulus();
      checkOutput("bp_drained", 64'(out_valid), 64'd0);

      // Credit exhaustion: slots 0,1 muldiv, slot 3 ALU, pointer back to 3
      reset = 1'b1;
      #1;
      reset      = 1'b0;
      req_valid  = 4'b1011;
      req_is_mdv = 4'b0011;
      #1;
      checkOutput("cr_first_ready", 64'(req_ready), 64'b0001);
      exp_sel  = '{2'd0, 2'd1, 2'd3, 2'd3};
      exp_mdv  = '{1'b1, 1'b1, 1'b0, 1'b0};
      exp_cred = '{4'd1, 4'd0, 4'd0, 4'd0};
      exp_rdy  = '{4'b0010, 4'b1000, 4'b1000, 4'b1000};
      for (int c = 0; c < 4; c++) begin
         applyStimulus();
         checkOutput("cr_out_sel", 64'(out_sel), 64'(exp_sel[c]));
         checkOutput("cr_out_is_mdv", 64'(out_is_mdv), 64'(exp_mdv[c]));
         checkOutput("cr_credits", 64'(mdv_credits), 64'(exp_cred[c]));
         checkOutput("cr_req_ready", 64'(req_ready), 64'(exp_rdy[c]));
      end

      // Credit return, then grant and return in the same cycle
      req_valid  = 4'b0001;
      req_is_mdv = 4'b0001;
      mdv_done   = 1'b1;
      #1;
      checkOutput("ret_blocked_ready", 64'(req_ready), 64'd0);
      applyStimulus();
      checkOutput("ret_credits", 64'(mdv_credits), 64'd1);
      checkOutput("ret_out_valid", 64'(out_valid), 64'd0);
      checkOutput("ret_req_ready", 64'(req_ready), 64'b0001);
      applyStimulus();
      checkOutput("both_credits", 64'(mdv_credits), 64'd1);
      checkOutput("both_out_sel", 64'(out_sel), 64'd0);
      checkOutput("both_out_is_mdv", 64'(out_is_mdv), 64'd1);
      mdv_done = 1'b0;
      applyStimulus();
      checkOutput("last_credit_used", 64'(mdv_credits), 64'd0);

      // Async reset while FULL with zero credits
      out_ready  = 1'b0;
      req_valid  = 4'h0;
      #1;
      checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
      checkOutput("pre_rst_credits", 64'(mdv_credits), 64'd0);
      req_valid  = 4'hF;
      req_is_mdv = 4'h0;
      out_ready  = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_out_valid", 64'(out_valid), 64'd0);
      checkOutput("async_credits", 64'(mdv_credits), 64'd2);
      checkOutput("async_req_ready", 64'(req_ready), 64'd0);

      // Stall window: full buffer, out_ready low, slot 2 pending
      req_valid = 4'b0100;
      out_ready = 1'b0;
      applyStimulus();
      reset = 1'b0;
      applyStimulus();
      checkOutput("stall_out_sel", 64'(out_sel), 64'd2);
      for (int i = 0; i < 10; i++) applyStimulus();
      checkOutput("stall_held_valid", 64'(out_valid), 64'd1);
`ifdef VX_ALU_SCHED_PERF_EN
      checkOutput("perf_stalls", 64'(perf_stalls), 64'd10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vx_alu_sched.md
VX_ALU_SCHED -- requirements
Module: VX_alu_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of issue slots sharing one ALU block.
REQ-002 SHALL have parameter DATAW, default 64, width of the opaque execute payload per slot.
REQ-003 SHALL have parameter MDV_CREDITS, default 4, maximum outstanding muldiv ops (range 1..15).
REQ-004 SHALL have ports clk (input, 1, sole clock) and reset (input, 1, asynchronous, active-high).
REQ-005 SHALL have port req_valid (input, NUM_REQS), per-slot request valid.
REQ-006 SHALL have port req_data (input, NUM_REQS*DATAW), per-slot payload, slot i at bits [i*DATAW +: DATAW].
REQ-007 SHALL have port req_is_mdv (input, NUM_REQS), per-slot flag marking a muldiv op.
REQ-008 SHALL have port req_ready (output, NUM_REQS), per-slot accept.
REQ-009 SHALL have ports out_valid (output, 1), out_data (output, DATAW), out_is_mdv (output, 1), out_sel (output, CLOG2(NUM_REQS) with UP), and out_ready (input, 1).
REQ-010 SHALL have port mdv_done (input, 1), a one-cycle pulse returning one muldiv credit.
REQ-011 SHALL have port mdv_credits (output, 4), current free credit count.

Function
REQ-012 Eligibility: slot i eligible iff req_valid[i] and (not req_is_mdv[i] or credits > 0).
REQ-013 Arbitration: round-robin among eligible slots, searching upward from the last granted slot + 1, wrapping modulo NUM_REQS.
REQ-014 Output buffer: one-entry register with states EMPTY and FULL.
REQ-015 Transitions: EMPTY→FULL on grant; FULL→EMPTY on out_ready with no new grant; FULL→FULL on out_ready with a new grant; FULL holds when out_ready is low.
REQ-016 A grant occurs only when the buffer is EMPTY or out_ready=1 in that cycle, so full throughput is sustained at one op per cycle.
REQ-017 req_ready[i] is 1 only for the granted slot (one-hot or zero), and is combinational from the inputs and state.
REQ-018 Latency: a granted request appears on out_* on the next clock edge.
REQ-019 out_data, out_is_mdv and out_sel are stable while out_valid=1 and out_ready=0.
REQ-020 Credits: decrement on a granted muldiv op and increment on mdv_done; when both occur in the same cycle, the count is unchanged.
REQ-021 Credits never exceed MDV_CREDITS: mdv_done at full credits is ignored, and an assertion fires in simulation.
REQ-022 At zero credits, muldiv slots are skipped and non-muldiv slots still win; no head-of-line blocking.
REQ-023 The round-robin pointer updates only on a grant.
REQ-024 A request dropped (valid deasserted) before it is granted leaves no effect on state.

Reset
REQ-025 Asynchronous reset SHALL force buffer EMPTY, out_valid=0, out_data=0, out_is_mdv=0, out_sel=0, rr pointer=NUM_REQS-1 (so slot 0 is first), and credits=MDV_CREDITS.
REQ-026 Reset mid-operation SHALL discard the buffered op and all credit history, and req_ready SHALL be 0 while reset is asserted.

Configuration
REQ-027 Macro VX_ALU_SCHED_PERF_EN SHALL gate the perf counter; when defined, it adds output perf_stalls (32-bit).
REQ-028 With VX_ALU_SCHED_PERF_EN defined, perf_stalls counts cycles where some req_valid=1 and no grant occurs; it wraps at 2^32 and is cleared by reset.
REQ-029 Without VX_ALU_SCHED_PERF_EN, the perf_stalls port and its counter are absent, and behaviour is otherwise identical.

Structure
REQ-030 A shared package SHALL hold the buffer state enum (ALU_SCHED_EMPTY, ALU_SCHED_FULL) and the credit-width constant (4).
REQ-031 The round-robin selector SHALL be a sub-module VX_alu_sched_rr, taking an eligible mask and pointer and returning a one-hot grant and an index.

Verification
REQ-032 After reset, with all four slots valid, non-muldiv, and out_ready=1, out_sel SHALL follow 0,1,2,3,0 on consecutive cycles.
REQ-033 With out_ready held 0 for 5 cycles and slot 2 valid, out_valid=1 and out_sel=2 SHALL hold stable, req_ready=0 while the buffer is FULL, and the op SHALL drain one cycle after out_ready=1.
REQ-034 With MDV_CREDITS=2, slots 0 and 1 muldiv, slot 3 ALU, and no mdv_done, two muldiv grants SHALL occur, then only slot 3 is granted, and mdv_credits=0.
REQ-035 At credits=1, a muldiv grant coinciding with mdv_done SHALL leave mdv_credits=1.
REQ-036 Asserting reset while the buffer is FULL and credits=0 SHALL give out_valid=0 and mdv_credits=MDV_CREDITS immediately, without waiting for a clock edge.
REQ-037 With VX_ALU_SCHED_PERF_EN defined, out_ready=0 for 10 cycles with a full buffer and a pending request SHALL produce perf_stalls=10.
